// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file write arbiter.
package regfile_pkg;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned NREGS = 32;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping at N-1.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] bin,
    output logic          valid
);

    always_comb begin
        int unsigned idx;
        gnt   = '0;
        bin   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!valid && req[idx]) begin
                valid    = 1'b1;
                bin      = PW'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbitration of NREQ writeback sources onto one register-file write port.
// Optional macro ZERO_REG_PROTECT_EN: writes to address 0 are accepted but discarded.
module regfile_wr_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned AW    = regfile_pkg::AW,
    parameter int unsigned DW    = regfile_pkg::DW,
    parameter int unsigned NREGS = regfile_pkg::NREGS,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               rf_stall,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [NREGS-1:0]   rf_wsel,
    output logic [DW-1:0]      rf_wdata,
    output logic [IW-1:0]      gnt_id
);

    import regfile_pkg::*;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_bin;
    logic            arb_valid;
    logic            accept;
    logic            xfer;
    logic            load;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .bin   (arb_bin),
        .valid (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        gnt_id_d = gnt_id_q;

        // The slot can take a new write if it is free or its write retires this cycle.
        accept    = (state_q == ST_EMPTY) || !rf_stall;
        req_ready = accept ? arb_gnt : '0;
        xfer      = accept && arb_valid;
        sel_addr  = req_addr[arb_bin*AW +: AW];
        sel_data  = req_data[arb_bin*DW +: DW];

`ifdef ZERO_REG_PROTECT_EN
        load = xfer && (sel_addr != '0);
`else
        load = xfer;
`endif

        if (xfer) begin
            ptr_d = (arb_bin == IW'(NREQ - 1)) ? '0 : arb_bin + IW'(1);
        end
        if ((state_q == ST_FULL) && !rf_stall) begin
            state_d = ST_EMPTY;
        end
        if (load) begin
            state_d  = ST_FULL;
            waddr_d  = sel_addr;
            wdata_d  = sel_data;
            gnt_id_d = arb_bin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            ptr_q    <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    always_comb begin
        rf_we    = (state_q == ST_FULL);
        rf_waddr = waddr_q;
        rf_wdata = wdata_q;
        gnt_id   = gnt_id_q;
        rf_wsel  = rf_we ? (NREGS'(1) << waddr_q) : '0;
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter (NREQ=2, AW=5, DW=32).
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        rf_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wsel;
    logic [31:0] rf_wdata;
    logic [0:0]  gnt_id;

    int checks;
    int errors;

    regfile_wr_arbiter #(
        .NREQ  (2),
        .AW    (5),
        .DW    (32),
        .NREGS (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_stall  (rf_stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wsel   (rf_wsel),
        .rf_wdata  (rf_wdata),
        .gnt_id    (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_write(input string tag, input logic [4:0] a, input logic [31:0] d,
                               input logic g);
        check({tag, ".we"}, 64'(rf_we), 64'd1);
        check({tag, ".waddr"}, 64'(rf_waddr), 64'(a));
        check({tag, ".wsel"}, 64'(rf_wsel), 64'(32'd1 << a));
        check({tag, ".wdata"}, 64'(rf_wdata), 64'(d));
        check({tag, ".gnt_id"}, 64'(gnt_id), 64'(g));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".we"}, 64'(rf_we), 64'd0);
        check({tag, ".wsel"}, 64'(rf_wsel), 64'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        rf_stall  = 1'b0;
        req_valid = 2'b11;
        req_addr  = {5'd2, 5'd1};
        req_data  = {32'h2222_2222, 32'h1111_1111};

        // 1: reset with both requesting, then alternating grants
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            settle();
            check_idle("rst_hold");
        end
        rst_n = 1'b1;
        settle();
        check("t1.ready0", 64'(req_ready), 64'b01);
        check_idle("t1.c0");
        next_cycle(); settle();
        check("t1.ready1", 64'(req_ready), 64'b10);
        check_write("t1.w0", 5'd1, 32'h1111_1111, 1'b0);
        next_cycle(); settle();
        check("t1.ready2", 64'(req_ready), 64'b01);
        check_write("t1.w1", 5'd2, 32'h2222_2222, 1'b1);
        next_cycle();
        req_valid = 2'b00;
        settle();
        check_write("t1.w2", 5'd1, 32'h1111_1111, 1'b0);
        next_cycle(); settle();
        check_idle("t1.drain");

        // 2: single pulse from req0
        next_cycle();
        req_valid = 2'b01;
        req_addr  = {5'd0, 5'd5};
        req_data  = {32'h0, 32'hDEAD_BEEF};
        settle();
        check("t2.ready", 64'(req_ready), 64'b01);

        // 3: stall for 3 cycles while FULL, req1 waiting
        next_cycle();
        req_valid = 2'b10;
        req_addr  = {5'd9, 5'd0};
        req_data  = {32'h1234_5678, 32'h0};
        rf_stall  = 1'b1;
        settle();
        check_write("t2.w", 5'd5, 32'hDEAD_BEEF, 1'b0);
        check("t3.ready_s0", 64'(req_ready), 64'b00);
        for (int i = 1; i < 3; i++) begin
            next_cycle(); settle();
            check_write("t3.frozen", 5'd5, 32'hDEAD_BEEF, 1'b0);
            check("t3.ready_s", 64'(req_ready), 64'b00);
        end
        next_cycle();
        rf_stall = 1'b0;
        settle();
        check("t3.ready_go", 64'(req_ready), 64'b10);
        check_write("t3.retire", 5'd5, 32'hDEAD_BEEF, 1'b0);
        next_cycle();
        req_valid = 2'b00;
        settle();
        check_write("t3.new", 5'd9, 32'h1234_5678, 1'b1);
        next_cycle(); settle();
        check_idle("t3.drain");

        // 4: move pointer to 1, then both target reg 7
        next_cycle();
        req_valid = 2'b01;
        req_addr  = {5'd0, 5'd3};
        req_data  = {32'h0, 32'h0000_0003};
        settle();
        check("t4.pre_ready", 64'(req_ready), 64'b01);
        next_cycle();
        req_valid = 2'b11;
        req_addr  = {5'd7, 5'd7};
        req_data  = {32'hBBBB_0001, 32'hAAAA_0000};
        settle();
        check("t4.ready_b", 64'(req_ready), 64'b10);
        check_write("t4.pre", 5'd3, 32'h0000_0003, 1'b0);
        next_cycle();
        req_valid = 2'b01;
        settle();
        check("t4.ready_a", 64'(req_ready), 64'b01);
        check_write("t4.wb", 5'd7, 32'hBBBB_0001, 1'b1);
        next_cycle();
        req_valid = 2'b00;
        settle();
        check_write("t4.wa", 5'd7, 32'hAAAA_0000, 1'b0);
        next_cycle(); settle();
        check_idle("t4.drain");

        // 5: asynchronous reset while FULL drops the pending write
        next_cycle();
        req_valid = 2'b10;
        req_addr  = {5'd12, 5'd0};
        req_data  = {32'hCAFE_F00D, 32'h0};
        next_cycle();
        req_valid = 2'b00;
        settle();
        check_write("t5.full", 5'd12, 32'hCAFE_F00D, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("t5.async");
        check("t5.waddr", 64'(rf_waddr), 64'd0);
        check("t5.wdata", 64'(rf_wdata), 64'd0);
        check("t5.gnt_id", 64'(gnt_id), 64'd0);
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_cycle(); settle();
            check_idle("t5.lost");
        end

`ifdef ZERO_REG_PROTECT_EN
        // 6: address-0 write is accepted and discarded, pointer still advances
        next_cycle();
        req_valid = 2'b01;
        req_addr  = {5'd0, 5'd0};
        req_data  = {32'h0, 32'hFFFF_FFFF};
        settle();
        check("t6.ready0", 64'(req_ready), 64'b01);
        next_cycle();
        req_valid = 2'b11;
        req_addr  = {5'd4, 5'd6};
        req_data  = {32'h4444_4444, 32'h6666_6666};
        settle();
        check_idle("t6.dropped");
        check("t6.ready1", 64'(req_ready), 64'b10);
        next_cycle();
        req_valid = 2'b00;
        settle();
        check_write("t6.w1", 5'd4, 32'h4444_4444, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
